// File: rtl/writeback_buffer_if.sv
// Bus bundle for writeback_buffer: the cache-controller request port and the
// main-memory port. The slave modport is the buffer's view. The master modport
// is the environment's view (requester plus memory).
interface writeback_buffer_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] cache_addr;
   logic [DATA_WIDTH-1:0] cache_wdata;
   logic                  cache_we;
   logic                  cache_re;
   logic [DATA_WIDTH-1:0] cache_rdata;
   logic                  cache_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_we;
   logic                  mem_re;
   logic                  mem_ready;

   modport slave (
      input  cache_addr, cache_wdata, cache_we, cache_re, mem_rdata, mem_ready,
      output cache_rdata, cache_ready, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output cache_addr, cache_wdata, cache_we, cache_re, mem_rdata, mem_ready,
      input  cache_rdata, cache_ready, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/writeback_buffer.sv
// Posted write buffer between the cache memory port and main memory.
// Evictions are absorbed in one cycle and queued in FIFO order. The queue
// drains in the background. Refill reads are checked against queued blocks.
// Optional macro WB_READ_FORWARD_EN: a read that hits a queued block is
// answered from the buffer. Without it, the read waits until draining has
// removed every matching entry.
module writeback_buffer #(
   parameter int DATA_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int OFFSET_BITS = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   writeback_buffer_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0]   buf_count,
   output logic                         buf_full,
   output logic                         buf_empty
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = ADDR_WIDTH - OFFSET_BITS;

   typedef enum logic [1:0] {IDLE, DRAIN_WR, MEM_RD, RESP} state_t;

   state_t                state, state_nxt;
   logic [BW-1:0]         blk_addr [DEPTH];
   logic [DATA_WIDTH-1:0] blk_data [DEPTH];
   logic [DEPTH-1:0]      valid;
   logic [PW-1:0]         head, tail;
   logic [CW-1:0]         count;
   logic                  ready_q, ready_nxt;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;

   logic [BW-1:0]         req_blk;
   logic                  wr_req, rd_req, in_flight, retire, full, empty;
   logic                  coal_hit, rd_hit, alloc;
   logic [PW-1:0]         coal_idx, idx;
   logic [PW:0]           sum;
   logic [DATA_WIDTH-1:0] fwd_data;

   logic                  mem_we_c, mem_re_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign buf_count = count;
   assign buf_full  = full;
   assign buf_empty = empty;

   assign bus.cache_ready = ready_q;
   assign bus.cache_rdata = rdata_q;
   assign bus.mem_we      = mem_we_c;
   assign bus.mem_re      = mem_re_c;
   assign bus.mem_addr    = mem_addr_c;
   assign bus.mem_wdata   = mem_wdata_c;

   // Block-address match against the queue, walked oldest to youngest so the last hit is the youngest.
   always_comb begin
      req_blk   = bus.cache_addr[ADDR_WIDTH-1:OFFSET_BITS];
      wr_req    = bus.cache_we && !ready_q;
      rd_req    = bus.cache_re && !bus.cache_we && !ready_q;
      in_flight = (state == DRAIN_WR);
      retire    = in_flight && bus.mem_ready;
      coal_hit  = 1'b0;
      coal_idx  = '0;
      rd_hit    = 1'b0;
      fwd_data  = '0;
      sum       = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         sum = {1'b0, head} + (PW+1)'(i);
         idx = (sum >= (PW+1)'(DEPTH)) ? PW'(sum - (PW+1)'(DEPTH)) : PW'(sum);
         if (valid[idx] && blk_addr[idx] == req_blk) begin
            rd_hit   = 1'b1;
            fwd_data = blk_data[idx];
            if (!(in_flight && idx == head)) begin
               coal_hit = 1'b1;
               coal_idx = idx;
            end
         end
      end
      // A retiring head frees its slot at this edge, so a full buffer can allocate in the same cycle.
      alloc = wr_req && !coal_hit && (!full || retire);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state, memory-port drive and cache response selection.
   always_comb begin
      state_nxt   = state;
      ready_nxt   = 1'b0;
      rdata_nxt   = rdata_q;
      mem_we_c    = 1'b0;
      mem_re_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      if (wr_req && (coal_hit || alloc)) ready_nxt = 1'b1;
      case (state)
         IDLE: begin
            if (rd_req) begin
`ifdef WB_READ_FORWARD_EN
               if (rd_hit) begin
                  state_nxt = RESP;
                  ready_nxt = 1'b1;
                  rdata_nxt = fwd_data;
               end else begin
                  state_nxt = MEM_RD;
               end
`else
               state_nxt = rd_hit ? DRAIN_WR : MEM_RD;
`endif
            end else if (!empty) begin
               state_nxt = DRAIN_WR;
            end
         end
         DRAIN_WR: begin
            mem_we_c    = 1'b1;
            mem_addr_c  = {blk_addr[head], {OFFSET_BITS{1'b0}}};
            mem_wdata_c = blk_data[head];
            if (bus.mem_ready) state_nxt = IDLE;
`ifdef WB_READ_FORWARD_EN
            // A hit is answered from the buffer while the drain keeps going.
            if (rd_req && rd_hit) begin
               ready_nxt = 1'b1;
               rdata_nxt = fwd_data;
            end
`endif
         end
         MEM_RD: begin
            mem_re_c   = 1'b1;
            mem_addr_c = bus.cache_addr;
            if (bus.mem_ready) begin
               state_nxt = RESP;
               ready_nxt = 1'b1;
               rdata_nxt = bus.mem_rdata;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Queue storage, pointers, occupancy and registered cache response.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid   <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_nxt;
         rdata_q <= rdata_nxt;
         if (retire) begin
            valid[head] <= 1'b0;
            head        <= ptr_inc(head);
         end
         if (wr_req && coal_hit) blk_data[coal_idx] <= bus.cache_wdata;
         if (alloc) begin
            valid[tail]    <= 1'b1;
            blk_addr[tail] <= req_blk;
            blk_data[tail] <= bus.cache_wdata;
            tail           <= ptr_inc(tail);
         end
         count <= count + CW'(alloc) - CW'(retire);
      end
   end
endmodule
